ccu_req_arbiter: RTL and testbench
==================================

# ccu_req_arbiter

Shares the single request port of the cache-coherency unit (CCU) between `NoSlvPorts` initiating ACE masters. It round-robin arbitrates AR/AW requests and locks the grant for the whole transaction: AR→R through `last`, or AW→W→B. It forwards only the granted master's channels to the CCU and routes the CCU's responses back to that master alone. It sits between the master-side interconnect ports and the CCU FSM request input.

## Interface
- `NoSlvPorts`, 4: number of initiating masters, ≥1.
- `mst_req_t`, logic: ACE request struct carrying AR, AW, W, `r_ready` and `b_ready`; the same type as the CCU request.
- `mst_resp_t`, logic: ACE response struct carrying the readies, R and B.
- `IdxWidth`, `(NoSlvPorts>1) ? $clog2(NoSlvPorts) : 1`: derived; not to be overridden.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `slv_req_i`  in  `[NoSlvPorts-1:0]` `mst_req_t`  requests from the masters.
- `slv_resp_o`  out  `[NoSlvPorts-1:0]` `mst_resp_t`  responses to the masters.
- `ccu_req_o`  out  `mst_req_t`  request to the CCU.
- `ccu_resp_i`  in  `mst_resp_t`  response from the CCU.
- `busy_o`  out  1  high in every state except IDLE.
- `sel_idx_o`  out  `IdxWidth`  index of the granted port; holds its last value while IDLE.

## Operation
- Registered state: `state_q`, `sel_q` (IdxWidth), `rr_ptr_q` (IdxWidth).
- States: IDLE, AR_FWD, R_FWD, AW_FWD, W_FWD, B_FWD.
- **IDLE**
  - Port `i` requests when `ar_valid | aw_valid`.
  - Pick the first requesting port at or after `rr_ptr_q`, wrapping modulo `NoSlvPorts`; store it in `sel_q`.
  - Next state is AR_FWD if that port's `ar_valid` is set, otherwise AW_FWD. AR wins when a port presents both.
  - With no request, stay in IDLE.
- **AR_FWD**
  - Drive `ccu_req_o.ar = slv_req_i[sel_q].ar` and `ccu_req_o.ar_valid = 1`.
  - Drive `slv_resp_o[sel_q].ar_ready = ccu_resp_i.ar_ready`.
  - On the AR handshake, go to R_FWD.
- **R_FWD**
  - Drive `slv_resp_o[sel_q].r = ccu_resp_i.r` and `r_valid = ccu_resp_i.r_valid`.
  - Drive `ccu_req_o.r_ready = slv_req_i[sel_q].r_ready`.
  - On an R handshake with `r.last = 1`, go to IDLE.
- **AW_FWD**: same as AR_FWD but on the AW channel; go to W_FWD on handshake.
- **W_FWD**
  - Forward W valid/payload downstream and `w_ready` back upstream for `sel_q`.
  - On a W handshake with `w.last = 1`, go to B_FWD.
- **B_FWD**
  - Forward `b`/`b_valid` to `sel_q` and `b_ready` to the CCU.
  - On the B handshake, go to IDLE.
- **Leaving R_FWD or B_FWD:** set `rr_ptr_q = (sel_q+1) mod NoSlvPorts`. A port presenting both AR and AW therefore gets its AW in a later round.
- **Masking**
  - Every non-granted port sees all valids and readies at 0.
  - In IDLE, every port sees all valids and readies at 0, and `ccu_req_o` is all-zero.
  - Payload fields of non-granted ports are 0.
- **Reset values:** `state_q = IDLE`, `sel_q = 0`, `rr_ptr_q = 0`, `busy_o = 0`, all outputs zero.
- **Reset mid-transaction:** return to IDLE immediately and drop all valids and readies. The CCU and the masters are reset together with this block.
- **AXI rules:** AXI stability rules are required of the masters. Withdrawing a valid before its handshake is unsupported and not checked.

## Timing
- Arbitration latency: a request first seen in IDLE in cycle 0 gives `ccu_req_o.ar_valid`/`aw_valid` = 1 in cycle 1.
- Channel muxing is combinational on `sel_q`; ready-to-ready and valid-to-valid paths have zero latency.
- Handshake-terminated states exit on the same edge as their completing handshake. The next grant earliest takes effect one cycle after IDLE is re-entered, giving 1 bubble cycle between transactions.
- Burst beats pass at full rate, one per cycle when both sides are ready.
- `NoSlvPorts = 1`: the arbiter degenerates to a pass-through with the one-cycle IDLE bubble; `rr_ptr_q` stays 0.

## Structure
- Shared package `ccu_pkg`: the state enum `ccu_arb_state_e`, and `rr_next()` as a function of pointer, request vector and `NoSlvPorts`.
- One sub-module `ccu_rr_picker` (purely combinational): inputs are the request vector and pointer; outputs are the `valid` flag and the selected index.
- The top level holds the FSM, registers and muxes.

## Test plan
- Single AR from port 2, 4-beat R, `last` on beat 4 → `ar_valid` to the CCU in cycle 1, 4 beats routed only to port 2, IDLE after beat 4, `rr_ptr = 3`.
- Ports 0, 1, 3 hold AR at the same time, starting from reset → grants in order 0, 1, 3, then 0 again once it re-requests; each grant 1 cycle after the previous IDLE.
- Port 1 AW plus a 2-beat W, with the CCU holding `b_valid` low for 5 cycles → `busy_o` stays 1, B delivered only to port 1, the other ports' `b_valid = 0`.
- Port 0 asserts AR and AW together → AR served first; AW is granted only after any other pending ports, and then `sel_idx_o = 0`.
- R backpressure: port 3 `r_ready` low for 3 cycles → `ccu_req_o.r_ready = 0` for those cycles, data held, no beat lost.
- `rst_ni` pulsed low during W_FWD → all outputs 0 asynchronously, `state = IDLE`, `rr_ptr = 0`, and a clean AR afterwards.

Source files
------------

// File: rtl/ccu_pkg.sv
// Shared types for the CCU request arbiter: FSM states, a default ACE request/response
// pair, and the round-robin search used by the picker.
package ccu_pkg;

  localparam int unsigned MaxPorts = 32;

  typedef enum logic [2:0] {
    IDLE,
    AR_FWD,
    R_FWD,
    AW_FWD,
    W_FWD,
    B_FWD
  } ccu_arb_state_e;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ace_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } ace_w_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } ace_r_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } ace_b_t;

  typedef struct packed {
    ace_ax_t ar;
    logic    ar_valid;
    ace_ax_t aw;
    logic    aw_valid;
    ace_w_t  w;
    logic    w_valid;
    logic    r_ready;
    logic    b_ready;
  } ace_req_t;

  typedef struct packed {
    logic   ar_ready;
    logic   aw_ready;
    logic   w_ready;
    ace_r_t r;
    logic   r_valid;
    ace_b_t b;
    logic   b_valid;
  } ace_resp_t;

  // First set bit of req at or after ptr, wrapping at n_ports; returns ptr when req is empty.
  // Scanning offsets from high to low lets the smallest offset win.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input logic [MaxPorts-1:0] req,
                                          input int unsigned n_ports);
    int unsigned idx;
    rr_next = ptr;
    for (int k = MaxPorts - 1; k >= 0; k--) begin
      if (k < int'(n_ports)) begin
        idx = (ptr + unsigned'(k)) % n_ports;
        if (req[idx[$clog2(MaxPorts)-1:0]]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/ccu_rr_picker.sv
// Combinational round-robin picker: selects the first requesting port at or after ptr.
module ccu_rr_picker
  import ccu_pkg::*;
#(
  parameter int unsigned NoSlvPorts = 4,
  localparam int unsigned IdxWidth = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1
) (
  input  logic [NoSlvPorts-1:0] req,
  input  logic [IdxWidth-1:0]   ptr,
  output logic                  valid,
  output logic [IdxWidth-1:0]   idx
);

  logic [MaxPorts-1:0] req_ext;

  always_comb begin
    req_ext = '0;
    req_ext[NoSlvPorts-1:0] = req;
  end

  assign valid = |req;
  assign idx   = IdxWidth'(rr_next(32'(ptr), req_ext, NoSlvPorts));

endmodule

// File: rtl/ccu_req_arbiter.sv
// Shares the CCU request port between NoSlvPorts ACE masters; the grant is held for a
// whole AR->R or AW->W->B transaction and only the granted master's channels are connected.
module ccu_req_arbiter
  import ccu_pkg::*;
#(
  parameter int unsigned NoSlvPorts = 4,
  parameter type mst_req_t  = ace_req_t,
  parameter type mst_resp_t = ace_resp_t,
  localparam int unsigned IdxWidth = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  mst_req_t  [NoSlvPorts-1:0]  slv_req_i,
  output mst_resp_t [NoSlvPorts-1:0]  slv_resp_o,
  output mst_req_t                    ccu_req_o,
  input  mst_resp_t                   ccu_resp_i,
  output logic                        busy_o,
  output logic [IdxWidth-1:0]         sel_idx_o
);

  ccu_arb_state_e      state_q, state_d;
  logic [IdxWidth-1:0] sel_q, sel_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] sel_inc;
  logic [IdxWidth-1:0] pick_idx;
  logic                pick_valid;
  logic [NoSlvPorts-1:0] req_vec;

  always_comb begin
    for (int i = 0; i < int'(NoSlvPorts); i++) begin
      req_vec[i] = slv_req_i[i].ar_valid | slv_req_i[i].aw_valid;
    end
  end

  ccu_rr_picker #(
    .NoSlvPorts(NoSlvPorts)
  ) i_picker (
    .req  (req_vec),
    .ptr  (rr_ptr_q),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign sel_inc = (sel_q == IdxWidth'(NoSlvPorts - 1)) ? '0 : sel_q + 1'b1;

  // Everything defaults to zero so idle and non-granted ports are fully masked.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    ccu_req_o  = '0;
    slv_resp_o = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          state_d = slv_req_i[pick_idx].ar_valid ? AR_FWD : AW_FWD;
        end
      end
      AR_FWD: begin
        ccu_req_o.ar                = slv_req_i[sel_q].ar;
        ccu_req_o.ar_valid          = 1'b1;
        slv_resp_o[sel_q].ar_ready  = ccu_resp_i.ar_ready;
        if (ccu_resp_i.ar_ready) state_d = R_FWD;
      end
      R_FWD: begin
        slv_resp_o[sel_q].r       = ccu_resp_i.r;
        slv_resp_o[sel_q].r_valid = ccu_resp_i.r_valid;
        ccu_req_o.r_ready         = slv_req_i[sel_q].r_ready;
        if (ccu_resp_i.r_valid && slv_req_i[sel_q].r_ready && ccu_resp_i.r.last) begin
          state_d  = IDLE;
          rr_ptr_d = sel_inc;
        end
      end
      AW_FWD: begin
        ccu_req_o.aw                = slv_req_i[sel_q].aw;
        ccu_req_o.aw_valid          = 1'b1;
        slv_resp_o[sel_q].aw_ready  = ccu_resp_i.aw_ready;
        if (ccu_resp_i.aw_ready) state_d = W_FWD;
      end
      W_FWD: begin
        ccu_req_o.w                = slv_req_i[sel_q].w;
        ccu_req_o.w_valid          = slv_req_i[sel_q].w_valid;
        slv_resp_o[sel_q].w_ready  = ccu_resp_i.w_ready;
        if (slv_req_i[sel_q].w_valid && ccu_resp_i.w_ready && slv_req_i[sel_q].w.last) begin
          state_d = B_FWD;
        end
      end
      B_FWD: begin
        slv_resp_o[sel_q].b       = ccu_resp_i.b;
        slv_resp_o[sel_q].b_valid = ccu_resp_i.b_valid;
        ccu_req_o.b_ready         = slv_req_i[sel_q].b_ready;
        if (ccu_resp_i.b_valid && slv_req_i[sel_q].b_ready) begin
          state_d  = IDLE;
          rr_ptr_d = sel_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign sel_idx_o = sel_q;

endmodule

// File: tb/tb_ccu_req_arbiter.sv
// Randomized bench for ccu_req_arbiter: masters and CCU are driven from a transaction-phase
// reference model that predicts every output of the arbiter each cycle.
module tb_ccu_req_arbiter;
  import ccu_pkg::*;

  localparam int N = 4;
  localparam int PH_IDLE = 0, PH_AR = 1, PH_R = 2, PH_AW = 3, PH_W = 4, PH_B = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  ace_req_t  [N-1:0]  slv_req;
  ace_resp_t [N-1:0]  slv_resp;
  ace_req_t           ccu_req;
  ace_resp_t          ccu_resp;
  logic               busy;
  logic [1:0]         sel_idx;

  always #5 clk = ~clk;

  ccu_req_arbiter #(
    .NoSlvPorts(N)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .ccu_req_o (ccu_req),
    .ccu_resp_i(ccu_resp),
    .busy_o    (busy),
    .sel_idx_o (sel_idx)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the port, which phase of the transaction it is in,
  // and where the next round-robin search starts.
  int      m_phase, m_owner, m_sel, m_ptr;
  bit      pend_ar[N], pend_aw[N];
  ace_ax_t ar_pl[N], aw_pl[N];
  int      beat, r_len, w_len, b_wait;
  bit      auto_req;
  int      force_rlen, force_wlen, force_bdelay;
  int      dut_grants[$];
  bit      prev_busy;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ace_ax_t randAx();
    ace_ax_t a;
    a.id   = 4'($urandom);
    a.addr = $urandom;
    a.len  = 8'($urandom);
    return a;
  endfunction

  function automatic bit anyPending();
    bit any = 1'b0;
    for (int p = 0; p < N; p++) any |= pend_ar[p] | pend_aw[p];
    return any;
  endfunction

  task automatic resetModel();
    m_phase = PH_IDLE; m_owner = 0; m_sel = 0; m_ptr = 0;
    beat = 0; r_len = 1; w_len = 1; b_wait = 0;
    for (int p = 0; p < N; p++) begin
      pend_ar[p] = 1'b0; pend_aw[p] = 1'b0;
      ar_pl[p] = randAx(); aw_pl[p] = randAx();
    end
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < N; p++) begin
      slv_req[p]          = '0;
      slv_req[p].ar       = ar_pl[p];
      slv_req[p].ar_valid = pend_ar[p];
      slv_req[p].aw       = aw_pl[p];
      slv_req[p].aw_valid = pend_aw[p];
      slv_req[p].w.data   = $urandom;
      slv_req[p].w.strb   = 4'($urandom);
      slv_req[p].r_ready  = ($urandom_range(3) != 0);
      slv_req[p].b_ready  = ($urandom_range(3) != 0);
      if (m_phase == PH_W && m_owner == p) begin
        slv_req[p].w.data  = 32'hD000_0000 + 32'(beat);
        slv_req[p].w.strb  = 4'hF;
        slv_req[p].w.last  = (beat == w_len - 1);
        slv_req[p].w_valid = ($urandom_range(2) != 0);
      end
    end
    ccu_resp          = '0;
    ccu_resp.ar_ready = 1'($urandom_range(1));
    ccu_resp.aw_ready = 1'($urandom_range(1));
    ccu_resp.w_ready  = ($urandom_range(3) != 0);
    ccu_resp.r.id     = 4'($urandom);
    ccu_resp.r.data   = $urandom;
    ccu_resp.r.resp   = 2'($urandom);
    ccu_resp.r.last   = 1'($urandom_range(1));
    if (m_phase == PH_R) begin
      ccu_resp.r.last  = (beat == r_len - 1);
      ccu_resp.r_valid = ($urandom_range(2) != 0);
    end
    ccu_resp.b.id    = 4'($urandom);
    ccu_resp.b.resp  = 2'($urandom);
    ccu_resp.b_valid = (m_phase == PH_B && b_wait == 0);
  endtask

  // Only the owner's channel of the current phase is connected; everything else is zero.
  task automatic checkCycle();
    ace_req_t  e_req;
    ace_resp_t e_resp[N];
    e_req = '0;
    for (int p = 0; p < N; p++) e_resp[p] = '0;
    case (m_phase)
      PH_AR: begin
        e_req.ar = slv_req[m_owner].ar; e_req.ar_valid = 1'b1;
        e_resp[m_owner].ar_ready = ccu_resp.ar_ready;
      end
      PH_R: begin
        e_resp[m_owner].r = ccu_resp.r; e_resp[m_owner].r_valid = ccu_resp.r_valid;
        e_req.r_ready = slv_req[m_owner].r_ready;
      end
      PH_AW: begin
        e_req.aw = slv_req[m_owner].aw; e_req.aw_valid = 1'b1;
        e_resp[m_owner].aw_ready = ccu_resp.aw_ready;
      end
      PH_W: begin
        e_req.w = slv_req[m_owner].w; e_req.w_valid = slv_req[m_owner].w_valid;
        e_resp[m_owner].w_ready = ccu_resp.w_ready;
      end
      PH_B: begin
        e_resp[m_owner].b = ccu_resp.b; e_resp[m_owner].b_valid = ccu_resp.b_valid;
        e_req.b_ready = slv_req[m_owner].b_ready;
      end
      default: ;
    endcase
    checkOutput("ccu_req", 256'(ccu_req), 256'(e_req));
    for (int p = 0; p < N; p++) checkOutput($sformatf("slv_resp%0d", p), 256'(slv_resp[p]), 256'(e_resp[p]));
    checkOutput("busy", 256'(busy), 256'(m_phase != PH_IDLE));
    checkOutput("sel_idx", 256'(sel_idx), 256'(m_sel));
    if (busy && !prev_busy) dut_grants.push_back(int'(sel_idx));
    prev_busy = busy;
  endtask

  task automatic updateModel();
    bit found = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        for (int k = 0; k < N; k++) begin
          int p = (m_ptr + k) % N;
          if (!found && (slv_req[p].ar_valid || slv_req[p].aw_valid)) begin
            found = 1'b1; m_owner = p; m_sel = p;
            m_phase = slv_req[p].ar_valid ? PH_AR : PH_AW;
          end
        end
      end
      PH_AR: if (ccu_resp.ar_ready) begin
        pend_ar[m_owner] = 1'b0; m_phase = PH_R; beat = 0;
        r_len = (force_rlen > 0) ? force_rlen : int'($urandom_range(4, 1));
      end
      PH_R: if (ccu_resp.r_valid && slv_req[m_owner].r_ready) begin
        if (beat == r_len - 1) begin m_phase = PH_IDLE; m_ptr = (m_owner + 1) % N; end
        else beat++;
      end
      PH_AW: if (ccu_resp.aw_ready) begin
        pend_aw[m_owner] = 1'b0; m_phase = PH_W; beat = 0;
        w_len = (force_wlen > 0) ? force_wlen : int'($urandom_range(4, 1));
      end
      PH_W: if (slv_req[m_owner].w_valid && ccu_resp.w_ready) begin
        if (beat == w_len - 1) begin
          m_phase = PH_B;
          b_wait = (force_bdelay > 0) ? force_bdelay : int'($urandom_range(3));
        end else beat++;
      end
      PH_B: begin
        if (ccu_resp.b_valid && slv_req[m_owner].b_ready) begin
          m_phase = PH_IDLE; m_ptr = (m_owner + 1) % N;
        end else if (b_wait > 0) b_wait--;
      end
      default: ;
    endcase
    if (auto_req) begin
      for (int p = 0; p < N; p++) begin
        if (!pend_ar[p] && $urandom_range(7) == 0) begin pend_ar[p] = 1'b1; ar_pl[p] = randAx(); end
        if (!pend_aw[p] && $urandom_range(7) == 0) begin pend_aw[p] = 1'b1; aw_pl[p] = randAx(); end
      end
    end
  endtask

  task automatic runCycle();
    @(posedge clk);
    #1;
    applyStimulus();
    @(negedge clk);
    checkCycle();
    updateModel();
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    do begin
      runCycle();
      n++;
    end while ((m_phase != PH_IDLE || anyPending()) && n < budget);
    if (m_phase != PH_IDLE || anyPending()) checkOutput("idle_timeout", 256'(1), 256'(0));
  endtask

  task automatic checkGrants(input string tag, input int exp[$]);
    checkOutput({tag, "_count"}, 256'(dut_grants.size()), 256'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < dut_grants.size()) checkOutput($sformatf("%s_%0d", tag, i), 256'(dut_grants[i]), 256'(exp[i]));
    end
    dut_grants.delete();
  endtask

  initial begin
    int n;
    auto_req = 1'b0; force_rlen = 0; force_wlen = 0; force_bdelay = 0; prev_busy = 1'b0;
    resetModel();
    slv_req = '0; ccu_resp = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkCycle();
    rst_n = 1'b1;

    // Three simultaneous readers from reset, then port 0 again.
    pend_ar[0] = 1'b1; pend_ar[1] = 1'b1; pend_ar[3] = 1'b1;
    runUntilIdle(300);
    pend_ar[0] = 1'b1;
    runUntilIdle(200);
    checkGrants("rr_order", '{0, 1, 3, 0});

    // Port 1 write, 2 W beats, B held off for 5 cycles.
    force_wlen = 2; force_bdelay = 5;
    pend_aw[1] = 1'b1;
    runUntilIdle(200);
    force_wlen = 0; force_bdelay = 0;
    checkGrants("write_p1", '{1});

    // Port 3 read brings the pointer to 0; port 0 then offers AR and AW while port 2 reads.
    pend_ar[3] = 1'b1;
    runUntilIdle(200);
    pend_ar[0] = 1'b1; pend_aw[0] = 1'b1; pend_ar[2] = 1'b1;
    runUntilIdle(400);
    checkGrants("ar_aw_same_port", '{3, 0, 2, 0});

    auto_req = 1'b1;
    repeat (1500) runCycle();
    auto_req = 1'b0;
    runUntilIdle(1000);
    dut_grants.delete();

    // 4-beat read from port 2 leaves the pointer at 3; then a write from port 2 is reset mid-W.
    force_rlen = 4;
    pend_ar[2] = 1'b1;
    runUntilIdle(200);
    force_rlen = 0;
    pend_aw[2] = 1'b1;
    n = 0;
    while (m_phase != PH_W && n < 100) begin
      runCycle();
      n++;
    end
    checkOutput("reach_w_phase", 256'(m_phase), 256'(PH_W));
    @(posedge clk);
    #1;
    applyStimulus();
    #1;
    checkOutput("busy_before_rst", 256'(busy), 256'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ccu_req", 256'(ccu_req), 256'(0));
    for (int p = 0; p < N; p++) checkOutput($sformatf("rst_slv_resp%0d", p), 256'(slv_resp[p]), 256'(0));
    checkOutput("rst_busy", 256'(busy), 256'(0));
    checkOutput("rst_sel_idx", 256'(sel_idx), 256'(0));
    resetModel();
    slv_req = '0; ccu_resp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    prev_busy = 1'b0;
    dut_grants.delete();

    // A freshly reset pointer must start the search at port 0.
    pend_ar[0] = 1'b1; pend_ar[3] = 1'b1;
    runUntilIdle(300);
    checkGrants("after_reset", '{0, 3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
